// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, branch condition encoding, BTB entry layout
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Tag field is sized for the widest legal tag; narrower TAG_W values are stored zero-extended.
    localparam int MAX_TAG_W = 30;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct_t;

    typedef struct packed {
        logic                 valid;
        logic                 jump;
        logic [MAX_TAG_W-1:0] tag;
        word_t                target;
    } btb_entry_t;

endpackage

// File: rtl/bpu_sat_counter.sv
// rtl/bpu_sat_counter.sv - saturating up/down counter with parallel load for one PHT entry
module bpu_sat_counter #(
    parameter int               CNT_W   = 2,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (inc && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (dec && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_branch_unit.sv
// rtl/execute_branch_unit.sv - BTB/PHT next-PC predictor with execute-stage branch resolution and training
module execute_branch_unit
    import cpu_types_pkg::*;
#(
    parameter int BTB_DEPTH = 16,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 2,
    parameter int PERF_W    = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  word_t             if_pc,
    output logic              pred_taken,
    output word_t             pred_target,
    input  logic              ex_valid,
    input  logic              ex_ihit,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic              ex_jalr,
    input  logic [2:0]        ex_funct3,
    input  word_t             ex_pc,
    input  word_t             ex_rdat1,
    input  word_t             ex_rdat2,
    input  word_t             ex_imm,
    input  word_t             ex_pred_target,
    output logic              redirect,
    output word_t             redirect_pc,
    output word_t             link_pc,
    output logic [PERF_W-1:0] branch_count,
    output logic [PERF_W-1:0] mispredict_count
);

    localparam int                IDX_W    = $clog2(BTB_DEPTH);
    localparam int                TAG_LO   = IDX_W + 2;
    localparam int                TAG_HI   = IDX_W + TAG_W + 1;
    localparam logic [CNT_W-1:0]  WEAK_NT  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  WEAK_T   = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    btb_entry_t       btb [BTB_DEPTH];
    logic [CNT_W-1:0] pht [BTB_DEPTH];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             is_ctrl, cond_taken, ex_taken, train;
    word_t            ex_target, actual_next;

    // Fetch-side lookup: zero latency, no bypass from a same-cycle training write.
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[TAG_HI:TAG_LO];
    assign if_hit      = btb[if_idx].valid && (btb[if_idx].tag == MAX_TAG_W'(if_tag));
    assign pred_taken  = if_hit && (btb[if_idx].jump || pht[if_idx][CNT_W-1]);
    assign pred_target = pred_taken ? btb[if_idx].target : if_pc + 32'd4;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];
    assign ex_hit = btb[ex_idx].valid && (btb[ex_idx].tag == MAX_TAG_W'(ex_tag));

    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3)
            BEQ:     cond_taken = (ex_rdat1 == ex_rdat2);
            BNE:     cond_taken = (ex_rdat1 != ex_rdat2);
            BLT:     cond_taken = ($signed(ex_rdat1) <  $signed(ex_rdat2));
            BGE:     cond_taken = ($signed(ex_rdat1) >= $signed(ex_rdat2));
            BLTU:    cond_taken = (ex_rdat1 <  ex_rdat2);
            BGEU:    cond_taken = (ex_rdat1 >= ex_rdat2);
            default: cond_taken = 1'b0;
        endcase
    end

    assign is_ctrl     = ex_branch || ex_jump || ex_jalr;
    assign ex_taken    = ex_jump || ex_jalr || (ex_branch && cond_taken);
    assign ex_target   = ex_jalr ? ((ex_rdat1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign actual_next = ex_taken ? ex_target : ex_pc + 32'd4;
    assign link_pc     = ex_pc + 32'd4;

    // Full next-PC compare, so a correct direction with a stale target still redirects.
    assign redirect    = ex_valid && (actual_next != ex_pred_target);
    assign redirect_pc = actual_next;

    assign train = ex_valid && ex_ihit && is_ctrl;

    for (genvar g = 0; g < BTB_DEPTH; g++) begin : g_pht
        bpu_sat_counter #(
            .CNT_W   (CNT_W),
            .RST_VAL (WEAK_NT)
        ) u_cnt (
            .clk      (CLK),
            .rst_n    (nRST),
            .en       (train && ex_hit && (ex_idx == IDX_W'(g))),
            .inc      (ex_taken),
            .dec      (!ex_taken),
            .load     (train && !ex_hit && ex_taken && (ex_idx == IDX_W'(g))),
            .load_val (WEAK_T),
            .cnt      (pht[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb[i] <= '0;
            end
        end else if (train && ex_taken) begin
            if (ex_hit) begin
                btb[ex_idx].target <= ex_target;
            end else begin
                btb[ex_idx].valid  <= 1'b1;
                btb[ex_idx].jump   <= ex_jump || ex_jalr;
                btb[ex_idx].tag    <= MAX_TAG_W'(ex_tag);
                btb[ex_idx].target <= ex_target;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (train) begin
            if (branch_count != PERF_MAX) begin
                branch_count <= branch_count + 1'b1;
            end
            if (redirect && mispredict_count != PERF_MAX) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule
